// File: rtl/led_pwm_fader.sv
// Eight-channel LED fader: each LED ramps its PWM brightness one step per fade
// tick towards the on/off target given by the registered pattern.
module led_pwm_fader #(
  parameter int PWM_BITS = 8,
  parameter int FADE_DIV = 97_656
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] pattern_in,
  input  logic       enable,
  output logic [7:0] led_out,
  output logic       busy
);

  localparam logic [PWM_BITS-1:0] LEVEL_MAX = '1;
  localparam int                  TICK_W    = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
  localparam logic [TICK_W-1:0]   TICK_LAST = TICK_W'(FADE_DIV - 1);

  logic [7:0]          pat_q;
  logic [PWM_BITS-1:0] pwm_q, pwm_d;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic [PWM_BITS-1:0] level_q [8];
  logic [PWM_BITS-1:0] level_d [8];
  logic [7:0]          led_q, led_d;
  logic                busy_q, busy_d;
  logic                fade_tick;

  // Free-running counters keep going with enable low so the PWM phase and the
  // tick cadence never slip relative to reset release.
  always_comb begin
    fade_tick = (tick_q == TICK_LAST);
    pwm_d     = pwm_q + PWM_BITS'(1);
    tick_d    = fade_tick ? '0 : tick_q + TICK_W'(1);
  end

  // Levels move one step toward the registered target and saturate at the ends;
  // using pat_q means a same-cycle pattern change only takes effect next tick.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      level_d[i] = level_q[i];
      if (fade_tick && enable) begin
        if (pat_q[i] && (level_q[i] != LEVEL_MAX)) begin
          level_d[i] = level_q[i] + PWM_BITS'(1);
        end else if (!pat_q[i] && (level_q[i] != '0)) begin
          level_d[i] = level_q[i] - PWM_BITS'(1);
        end
      end
    end
  end

  // Full-scale level is forced high so the LED is truly constant-on instead of
  // dropping out once per PWM period.
  always_comb begin
    led_d  = '0;
    busy_d = 1'b0;
    for (int i = 0; i < 8; i++) begin
      led_d[i] = enable && ((level_q[i] == LEVEL_MAX) || (pwm_q < level_q[i]));
      if (pat_q[i] ? (level_q[i] != LEVEL_MAX) : (level_q[i] != '0)) begin
        busy_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_q  <= '0;
      pwm_q  <= '0;
      tick_q <= '0;
      led_q  <= '0;
      busy_q <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        level_q[i] <= '0;
      end
    end else begin
      pat_q  <= pattern_in;
      pwm_q  <= pwm_d;
      tick_q <= tick_d;
      led_q  <= led_d;
      busy_q <= busy_d;
      for (int i = 0; i < 8; i++) begin
        level_q[i] <= level_d[i];
      end
    end
  end

  assign led_out = led_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_led_pwm_fader.sv
// Bench for led_pwm_fader: hand-derived vector table, long-tick duty sequence,
// async reset, and randomized patterns checked against an integer model.
module tb_led_pwm_fader;

  localparam int FD   = 4;
  localparam int MAXL = 7;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] pattern_in = '0;
  logic       enable = 1'b0;
  logic [7:0] led_out;
  logic       busy;

  logic [7:0] pattern2 = '0;
  logic       enable2 = 1'b0;
  logic [7:0] led2;
  logic       busy2;

  led_pwm_fader #(.PWM_BITS(3), .FADE_DIV(FD)) dut (
    .clk(clk), .rst_n(rst_n), .pattern_in(pattern_in), .enable(enable),
    .led_out(led_out), .busy(busy)
  );

  led_pwm_fader #(.PWM_BITS(3), .FADE_DIV(40)) dut2 (
    .clk(clk), .rst_n(rst_n), .pattern_in(pattern2), .enable(enable2),
    .led_out(led2), .busy(busy2)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int failures = 0;

  // Reference state: cycles elapsed since reset release plus integer brightness.
  int         mLvl [8];
  logic [7:0] mPat;
  int         mCyc;
  logic [7:0] mLed;
  logic       mBusy;

  typedef struct {
    logic [7:0] pat;
    logic       en;
    int         cycles;
    logic [7:0] expLed;
    logic       expBusy;
  } vec_t;

  vec_t vecs [10];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 8; i++) mLvl[i] = 0;
    mPat  = '0;
    mCyc  = 0;
    mLed  = '0;
    mBusy = 1'b0;
  endtask

  task automatic modelEdge(input logic [7:0] pin, input logic en);
    int         phase;
    bit         tick;
    logic [7:0] nLed;
    logic       nBusy;
    phase = mCyc % 8;
    tick  = ((mCyc % FD) == FD - 1);
    nBusy = 1'b0;
    for (int i = 0; i < 8; i++) begin
      nLed[i] = en && ((mLvl[i] == MAXL) || (phase < mLvl[i]));
      if (mPat[i] ? (mLvl[i] != MAXL) : (mLvl[i] != 0)) nBusy = 1'b1;
    end
    if (tick && en) begin
      for (int i = 0; i < 8; i++) begin
        if (mPat[i]) mLvl[i] = (mLvl[i] + 1 > MAXL) ? MAXL : mLvl[i] + 1;
        else         mLvl[i] = (mLvl[i] - 1 < 0) ? 0 : mLvl[i] - 1;
      end
    end
    mLed  = nLed;
    mBusy = nBusy;
    mPat  = pin;
    mCyc++;
  endtask

  task automatic applyStimulus(input logic [7:0] pat, input logic en);
    pattern_in = pat;
    enable     = en;
    modelEdge(pat, en);
    @(posedge clk);
    #1;
    checkOutput("model_led", 32'(led_out), 32'(mLed));
    checkOutput("model_busy", 32'(busy), 32'(mBusy));
  endtask

  task automatic doReset();
    rst_n      = 1'b0;
    pattern_in = '0;
    enable     = 1'b0;
    pattern2   = '0;
    enable2    = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("reset_led", 32'(led_out), 32'h0);
    checkOutput("reset_busy", 32'(busy), 32'h0);
    checkOutput("reset_led2", 32'(led2), 32'h0);
    #3;
    rst_n = 1'b1;
    modelReset();
  endtask

  initial begin
    int winStart [9];
    int winExp   [9];
    int winCnt   [9];
    logic [7:0] rp;
    int hold;
    int drop;

    // Expected values derived by hand for FADE_DIV=4, three-bit levels.
    vecs[0] = '{8'h1F, 1'b1, 1,  8'h00, 1'b0};
    vecs[1] = '{8'h1F, 1'b1, 1,  8'h00, 1'b1};
    vecs[2] = '{8'h1F, 1'b1, 30, 8'h1F, 1'b0};
    vecs[3] = '{8'h1F, 1'b0, 1,  8'h00, 1'b0};
    vecs[4] = '{8'h00, 1'b1, 1,  8'h1F, 1'b0};
    vecs[5] = '{8'h00, 1'b1, 1,  8'h1F, 1'b1};
    vecs[6] = '{8'h00, 1'b1, 1,  8'h1F, 1'b1};
    vecs[7] = '{8'h00, 1'b1, 1,  8'h1F, 1'b1};
    vecs[8] = '{8'h00, 1'b1, 2,  8'h00, 1'b1};
    vecs[9] = '{8'h00, 1'b1, 30, 8'h00, 1'b0};

    winStart = '{121, 201, 241, 281, 321, 361, 401, 441, 481};
    winExp   = '{3,   5,   4,   3,   2,   1,   0,   0,   0};
    for (int w = 0; w < 9; w++) winCnt[w] = 0;

    doReset();
    for (int k = 0; k < 10; k++) begin
      repeat (vecs[k].cycles) applyStimulus(vecs[k].pat, vecs[k].en);
      checkOutput($sformatf("vec%0d_led", k), 32'(led_out), 32'(vecs[k].expLed));
      checkOutput($sformatf("vec%0d_busy", k), 32'(busy), 32'(vecs[k].expBusy));
    end

    // Slow-tick instance: hold level 3, then clear the target on the tick edge
    // of level 5 and watch the duty step down without wrapping.
    doReset();
    enable2 = 1'b1;
    for (int e = 1; e <= 488; e++) begin
      pattern2 = (e < 200) ? 8'h01 : 8'h00;
      @(posedge clk);
      #1;
      for (int w = 0; w < 9; w++) begin
        if (e >= winStart[w] && e < winStart[w] + 8) winCnt[w] += int'(led2[0]);
      end
      if (e >= 121 && e < 129) checkOutput("duty3_phase", 32'(led2[0]), 32'((e - 121) < 3));
      if (e == 204) checkOutput("busy2_ramp", 32'(busy2), 32'h1);
    end
    for (int w = 0; w < 9; w++) checkOutput($sformatf("duty_win%0d", w), 32'(winCnt[w]), 32'(winExp[w]));
    checkOutput("busy2_settled", 32'(busy2), 32'h0);
    checkOutput("led2_upper", 32'(led2[7:1]), 32'h0);

    // Asynchronous reset between clock edges while every LED is mid-ramp.
    doReset();
    repeat (10) applyStimulus(8'hFF, 1'b1);
    checkOutput("pre_async_busy", 32'(busy), 32'h1);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async_led", 32'(led_out), 32'h0);
    checkOutput("async_busy", 32'(busy), 32'h0);
    #1;
    rst_n = 1'b1;
    modelReset();
    repeat (40) applyStimulus(8'hFF, 1'b1);

    // Random targets with occasional 12-cycle enable drops.
    rp   = 8'h00;
    hold = 0;
    drop = 0;
    for (int c = 0; c < 2000; c++) begin
      if (hold == 0) begin
        rp   = 8'($urandom);
        hold = $urandom_range(5, 60);
      end
      hold--;
      if (drop == 0 && $urandom_range(0, 39) == 0) drop = 12;
      applyStimulus(rp, drop == 0);
      if (drop > 0) drop--;
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
